// File: rtl/generator_mc.sv
// Multi-channel SPI DAC waveform generator: NCH phase accumulators serialised
// round-robin as 32-bit write-and-update frames to the board DAC.
module generator_mc #(
    parameter int DIV   = 3,
    parameter int NCH   = 4,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [2*NCH-1:0]     mode,
    input  logic [ACC_W*NCH-1:0] step,
    output logic                 spi_mosi,
    output logic                 spi_sck,
    output logic                 dac_cs,
    output logic                 dac_clr,
    output logic                 busy,
    output logic                 frame_done
);
    // state | meaning
    // IDLE  | cs high, waiting for enable once the DAC clear is released
    // LOAD  | frame built for the current channel, cs low, first bit on mosi
    // SHIFT | 32 bits out, each bit sck low for DIV cycles then high for DIV
    // END   | cs high gap; last cycle advances accumulator and channel
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_END} state_t;

    localparam int CW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV);
    localparam logic [3:0]    CH_LAST  = 4'(NCH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [4:0]       bcnt;
    logic [31:0]      shreg;
    logic [3:0]       ch;
    logic [ACC_W-1:0] lat_step;
    logic [ACC_W-1:0] acc [NCH];

    logic [12:0]      cur_top;
    logic [1:0]       cur_mode;
    logic [ACC_W-1:0] cur_step;
    logic [11:0]      data;
    logic [31:0]      frame_word;

    always_comb begin
        cur_top  = '0;
        cur_mode = '0;
        cur_step = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == 4'(i)) begin
                cur_top  = acc[i][ACC_W-1 -: 13];
                cur_mode = mode[2*i +: 2];
                cur_step = step[ACC_W*i +: ACC_W];
            end
        end
    end

    // cur_top[12] is the accumulator MSB; cur_top[11:0] is the triangle ramp
    always_comb begin
        case (cur_mode)
            2'b00:   data = cur_top[12:1];
            2'b01:   data = cur_top[12] ? ~cur_top[11:0] : cur_top[11:0];
            2'b10:   data = cur_top[12] ? 12'h000 : 12'hFFF;
            default: data = 12'h800;
        endcase
        frame_word = {8'h00, 4'b0011, ch, data, 4'h0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dac_cs     = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        frame_done = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (enable && dac_clr) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                dac_cs    = 1'b0;
                spi_mosi  = frame_word[31];
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                dac_cs   = 1'b0;
                spi_mosi = shreg[31];
                spi_sck  = (cnt < CNT_DIV);
                if (cnt == '0 && bcnt == 5'd31) state_nxt = ST_END;
            end
            ST_END: begin
                if (cnt == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Step is captured at LOAD so a mid-frame change only affects the next visit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_clr  <= 1'b0;
            cnt      <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            ch       <= '0;
            lat_step <= '0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
            dac_clr <= 1'b1;
            case (state)
                ST_LOAD: begin
                    shreg    <= frame_word;
                    lat_step <= cur_step;
                    cnt      <= CNT_LAST;
                    bcnt     <= '0;
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        cnt <= CNT_LAST;
                        if (bcnt != 5'd31) begin
                            bcnt  <= bcnt + 5'd1;
                            shreg <= {shreg[30:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_END: begin
                    if (cnt == '0) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (ch == 4'(i)) acc[i] <= acc[i] + lat_step;
                        end
                        ch <= (ch == CH_LAST) ? 4'd0 : ch + 4'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_generator_mc.sv
// Self-checking bench for generator_mc: decodes SPI frames from the pins and
// compares them with an arithmetic model of the per-channel accumulators.
module tb_generator_mc;
    localparam int DIV    = 3;
    localparam int NCH    = 4;
    localparam int ACC_W  = 16;
    localparam int PERIOD = 1 + 66 * DIV;
    localparam int CS_LOW = 64 * DIV + 1;

    logic                 clk    = 1'b0;
    logic                 rst    = 1'b0;
    logic                 enable = 1'b0;
    logic [2*NCH-1:0]     mode   = '0;
    logic [ACC_W*NCH-1:0] step   = '0;
    logic spi_mosi, spi_sck, dac_cs, dac_clr, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int unsigned acc_m [NCH];
    int          ch_m = 0;

    generator_mc #(.DIV(DIV), .NCH(NCH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .step(step),
        .spi_mosi(spi_mosi), .spi_sck(spi_sck), .dac_cs(dac_cs),
        .dac_clr(dac_clr), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned sample(input int unsigned md, input int unsigned a);
        int unsigned t  = (a >> (ACC_W - 13)) % 4096;
        bit          hi = ((a >> (ACC_W - 1)) % 2) == 1;
        case (md)
            0:       return a >> (ACC_W - 12);
            1:       return hi ? 4095 - t : t;
            2:       return hi ? 0 : 4095;
            default: return 2048;
        endcase
    endfunction

    function automatic logic [31:0] exp_frame(input int c, input int unsigned md, input int unsigned a);
        return (32'h3 << 20) | (32'(c) << 16) | (32'(sample(md, a)) << 4);
    endfunction

    task automatic model_check(input string tag, input logic [31:0] bits,
                               input int unsigned md, input int unsigned st);
        chk({tag, " frame"}, bits, exp_frame(ch_m, md, acc_m[ch_m]));
        acc_m[ch_m] = (acc_m[ch_m] + st) % (1 << ACC_W);
        ch_m = (ch_m + 1) % NCH;
    endtask

    task automatic do_reset(input string tag);
        rst    = 1'b0;
        enable = 1'b0;
        repeat (2) tick();
        chk({tag, " rst cs"},   32'(dac_cs),     32'd1);
        chk({tag, " rst sck"},  32'(spi_sck),    32'd0);
        chk({tag, " rst mosi"}, 32'(spi_mosi),   32'd0);
        chk({tag, " rst clr"},  32'(dac_clr),    32'd0);
        chk({tag, " rst busy"}, 32'(busy),       32'd0);
        chk({tag, " rst done"}, 32'(frame_done), 32'd0);
        rst = 1'b1;
        #1;
        chk({tag, " clr before edge"}, 32'(dac_clr), 32'd0);
        tick();
        chk({tag, " clr after edge"}, 32'(dac_clr), 32'd1);
        tick();
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < NCH; i++) acc_m[i] = 0;
        ch_m = 0;
    endtask

    // act_kind: 1 = disturb current channel's mode/step, 2 = drop enable, 3 = assert rst
    task automatic capture(input string tag, input int act_bit, input int act_kind,
                           output logic [31:0] bits, output int unsigned md,
                           output int unsigned st, output int start_cyc, output bit aborted);
        int   wait_cnt = 0;
        int   cs_low   = 0;
        int   n_rise   = 0;
        bit   stable   = 1'b1;
        bit   end_ok   = 1'b1;
        logic prev_sck = 1'b0;
        logic prev_mosi;
        logic rise_mosi = 1'b0;
        bits    = '0;
        aborted = 1'b0;
        md = 0; st = 0; start_cyc = cyc;
        while (dac_cs !== 1'b0 && wait_cnt < 4 * PERIOD) begin
            tick();
            wait_cnt++;
        end
        chk({tag, " cs fall"}, 32'(dac_cs), 32'd0);
        if (dac_cs !== 1'b0) begin
            aborted = 1'b1;
            return;
        end
        md        = mode[2*ch_m +: 2];
        st        = step[ACC_W*ch_m +: ACC_W];
        start_cyc = cyc;
        chk({tag, " done low at load"}, 32'(frame_done), 32'd0);
        prev_mosi = spi_mosi;
        while (dac_cs === 1'b0 && cs_low < 2 * PERIOD) begin
            cs_low++;
            if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
                bits      = {bits[30:0], spi_mosi};
                rise_mosi = spi_mosi;
                if (spi_mosi !== prev_mosi) stable = 1'b0;
                n_rise++;
                if (n_rise == act_bit) begin
                    case (act_kind)
                        1: begin
                            mode[2*ch_m +: 2] = ~mode[2*ch_m +: 2];
                            step[ACC_W*ch_m +: ACC_W] = step[ACC_W*ch_m +: ACC_W]
                                                        + ACC_W'(1 + $urandom_range(0, 999));
                        end
                        2: enable = 1'b0;
                        3: begin
                            rst = 1'b0;
                            #1;
                            chk({tag, " abort cs"},   32'(dac_cs),  32'd1);
                            chk({tag, " abort sck"},  32'(spi_sck), 32'd0);
                            chk({tag, " abort busy"}, 32'(busy),    32'd0);
                            aborted = 1'b1;
                            return;
                        end
                        default: ;
                    endcase
                end
            end else if (spi_sck === 1'b1 && spi_mosi !== rise_mosi) begin
                stable = 1'b0;
            end
            prev_sck  = spi_sck;
            prev_mosi = spi_mosi;
            tick();
        end
        chk({tag, " cs low cycles"}, 32'(cs_low), 32'(CS_LOW));
        chk({tag, " sck rises"},     32'(n_rise), 32'd32);
        chk({tag, " mosi stable"},   32'(stable), 32'd1);
        wait_cnt = 0;
        while (frame_done !== 1'b1 && wait_cnt < 2 * DIV + 2) begin
            if (spi_sck !== 1'b0 || spi_mosi !== 1'b0 || dac_cs !== 1'b1) end_ok = 1'b0;
            tick();
            wait_cnt++;
        end
        chk({tag, " frame_done"},   32'(frame_done),      32'd1);
        chk({tag, " end idle pins"}, 32'(end_ok),         32'd1);
        chk({tag, " done offset"},  32'(cyc - start_cyc), 32'(PERIOD - 1));
    endtask

    initial begin
        logic [31:0] bits;
        int unsigned md, st;
        int          st_cyc, prev_start, cs_seen, ak;
        bit          ab;
        int unsigned tri_tab [8] = '{12'h000, 12'h400, 12'h800, 12'hC00,
                                     12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF};
        int unsigned sq_tab  [4] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000};

        do_reset("init");

        // all channels constant midscale; steps random but data must not move
        mode = '1;
        for (int i = 0; i < NCH; i++) step[ACC_W*i +: ACC_W] = ACC_W'($urandom);
        enable = 1'b1;
        prev_start = 0;
        for (int k = 0; k < 5; k++) begin
            capture($sformatf("const f%0d", k), -1, 0, bits, md, st, st_cyc, ab);
            chk($sformatf("const f%0d word", k), bits, 32'h00308000 | (32'(k % NCH) << 16));
            model_check($sformatf("const f%0d", k), bits, md, st);
            if (k > 0) chk($sformatf("const f%0d period", k), 32'(st_cyc - prev_start), 32'(PERIOD));
            prev_start = st_cyc;
        end

        do_reset("wave");
        mode = 8'b11_10_01_00;
        step[ACC_W*0 +: ACC_W] = 16'h1000;
        step[ACC_W*1 +: ACC_W] = 16'h2000;
        step[ACC_W*2 +: ACC_W] = 16'h4000;
        step[ACC_W*3 +: ACC_W] = ACC_W'($urandom);
        enable = 1'b1;
        for (int r = 0; r < 17; r++) begin
            for (int c = 0; c < NCH; c++) begin
                ak = (r == 5 && c == 2) ? 1 : 0;
                capture($sformatf("wave r%0d c%0d", r, c), ak == 1 ? 12 : -1, ak,
                        bits, md, st, st_cyc, ab);
                if (c == 0) chk($sformatf("saw r%0d", r), 32'(bits[15:4]), 32'((r * 256) % 4096));
                if (c == 1) chk($sformatf("tri r%0d", r), 32'(bits[15:4]), 32'(tri_tab[r % 8]));
                if (c == 2) chk($sformatf("sq r%0d", r),  32'(bits[15:4]), 32'(sq_tab[r % 4]));
                model_check($sformatf("wave r%0d c%0d", r, c), bits, md, st);
                if (ak == 1) begin
                    mode[5:4] = 2'b10;
                    step[ACC_W*2 +: ACC_W] = 16'h4000;
                end
            end
        end

        // random modes and steps, changed at frame boundaries
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) begin
                mode = (2*NCH)'($urandom);
                for (int i = 0; i < NCH; i++) step[ACC_W*i +: ACC_W] = ACC_W'($urandom);
            end
            capture($sformatf("rand f%0d", k), -1, 0, bits, md, st, st_cyc, ab);
            model_check($sformatf("rand f%0d", k), bits, md, st);
        end

        // enable dropped at bit 10: frame completes, then the block parks
        capture("drop", 10, 2, bits, md, st, st_cyc, ab);
        model_check("drop", bits, md, st);
        tick();
        chk("drop busy after end", 32'(busy), 32'd0);
        cs_seen = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (dac_cs !== 1'b1 || frame_done !== 1'b0) cs_seen++;
            tick();
        end
        chk("drop no further frame", 32'(cs_seen), 32'd0);

        // reset pulled at bit 20: restart must begin at channel 0 with acc = 0
        enable = 1'b1;
        capture("abort", 20, 3, bits, md, st, st_cyc, ab);
        chk("abort taken", 32'(ab), 32'd1);
        mode = '0;
        do_reset("restart");
        enable = 1'b1;
        capture("restart f0", -1, 0, bits, md, st, st_cyc, ab);
        chk("restart f0 word", bits, 32'h00300000);
        model_check("restart f0", bits, md, st);
        capture("restart f1", -1, 0, bits, md, st, st_cyc, ab);
        chk("restart f1 word", bits, 32'h00310000);
        model_check("restart f1", bits, md, st);
        enable = 1'b0;
        repeat (PERIOD) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/generator_mc.md
Name: generator_mc

Overview:
Multi-channel successor to the single-output SPI DAC waveform generator. It holds NCH independent phase accumulators, each producing sawtooth, triangle, square or constant-midscale samples. Samples are serialised round-robin as 32-bit write-and-update frames to the board DAC over SPI. It sits at top level between the clock/reset pins and the DAC pins (spi_mosi, spi_sck, dac_cs, dac_clr).

Parameters:
DIV, 3, SCK half-period in clk cycles (>=1)
NCH, 4, channel count (1..16; channel index is the 4-bit DAC address)
ACC_W, 16, phase accumulator / step width (>=13)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  1 = keep issuing frames; sampled only in IDLE and at end of frame
mode  in  2*NCH  per-channel waveform, channel i at [2i+1:2i]: 00 saw, 01 triangle, 10 square, 11 const 0x800
step  in  ACC_W*NCH  per-channel phase increment, channel i at [ACC_W*(i+1)-1:ACC_W*i]
spi_mosi  out  1  serial data, MSB first
spi_sck  out  1  SPI clock, idle low
dac_cs  out  1  DAC chip select, active low
dac_clr  out  1  DAC clear, active low
busy  out  1  1 when state != IDLE
frame_done  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
- Reset (rst=0, async): dac_cs=1, spi_sck=0, spi_mosi=0, dac_clr=0, busy=0, frame_done=0, all accumulators=0, channel index=0, state=IDLE.
- dac_clr rises to 1 on the first clk edge after rst returns to 1, then stays 1.
- FSM states:
  - IDLE: cs=1. Goes to LOAD when enable=1 and dac_clr=1.
  - LOAD: 1 cycle. Latches mode/step of the current channel and builds the frame {8'h00, 4'b0011, ch[3:0], data[11:0], 4'h0}. Drives cs=0 and mosi=frame[31].
  - SHIFT: 32 bits, each 2*DIV cycles: sck=0 for DIV cycles, then sck=1 for DIV cycles. mosi updates only at bit start, while sck=0. Total 64*DIV cycles.
  - END: cs=1, sck=0, mosi=0 for 2*DIV cycles. On the last END cycle:
    - frame_done=1
    - acc[ch] += latched step, modulo 2^ACC_W
    - ch = (ch==NCH-1) ? 0 : ch+1
    - next state is LOAD if enable=1, else IDLE.
- Frame period with continuous enable: 1 + 64*DIV + 2*DIV cycles (199 at DIV=3). cs is low for 64*DIV+1 cycles.
- Sample data from acc a, M = a[ACC_W-1]:
  - saw: a[ACC_W-1 -: 12]
  - triangle: M=0 gives a[ACC_W-2 -: 12]; M=1 gives the bitwise inverse of a[ACC_W-2 -: 12]
  - square: M=0 gives 0xFFF; M=1 gives 0x000
  - const: 0x800 (accumulator still advances)
- Boundaries:
  - enable dropped mid-frame: the frame completes, frame_done pulses, then IDLE.
  - mode/step changed mid-frame: no effect until that channel's next LOAD.
  - Accumulator wraps silently.
  - NCH=1: every frame addresses channel 0.
  - rst asserted mid-SHIFT: immediate abort to reset values, no partial update of the accumulator.

Test Plan:
- Reset: hold rst=0 -> cs=1, sck=0, mosi=0, clr=0, busy=0. Release -> clr=1 after one clk, busy still 0 while enable=0.
- DIV=3, NCH=4, all mode=11, enable=1:
  - frame bits are 32'h00308000, 32'h00318000, 32'h00328000, 32'h00338000, 32'h00308000
  - frame period 199 clk, cs low 193 clk, sck 32 rising edges per frame, mosi stable at each rising edge
- Sawtooth ch0, step=16'h1000: successive ch0 data words 0x000, 0x100, 0x200 … 0xF00, then 0x000 (wrap after 16 samples).
- Triangle ch1, step=16'h2000: ch1 data 0x000, 0x400, 0x800, 0xC00, 0xFFF, 0xBFF, 0x7FF, 0x3FF, then repeat.
- Square ch2, step=16'h4000: ch2 data 0xFFF, 0xFFF, 0x000, 0x000, then repeat. Changing ch2 step mid-frame does not alter the sample in flight.
- Abort cases:
  - drop enable at bit 10 of a frame -> remaining 22 bits sent, one frame_done, busy=0 after END
  - pull rst low at bit 20 of the next frame -> cs=1 and sck=0 asynchronously, and the next frame after restart is channel 0 with data from acc=0
